shift_sched: RTL
================

// Module: shift_sched
// PURPOSE
//  Round-robin scheduler sharing one registered barrel_shifter instance among NREQ requesters.
//  Accepts per-requester valid/ready shift commands and drives the shifter's control/data inputs.
//  Returns each result on a single valid/ready response port, tagged with the requester ID.
//  Sits between client datapaths and the shared shifter; one transaction in flight at a time.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  BUSWIDTH   32   data width; must equal 2**SHIFTWIDTH (elaboration-time $error otherwise)
//  SHIFTWIDTH  5   shift-amount width
//  IDW $clog2(NREQ) localparam, response ID width
// PORTS
//  clk          in   1                 clock, all logic on posedge
//  rst          in   1                 async active-high reset
//  req_valid    in   NREQ              per-requester command valid
//  req_ready    out  NREQ              per-requester accept (one-hot or zero)
//  req_data     in   NREQ*BUSWIDTH     operand, requester i at [i*BUSWIDTH +: BUSWIDTH]
//  req_rot      in   NREQ              1=rotate, 0=logical shift
//  req_dir      in   NREQ              0=left, 1=right
//  req_shamt    in   NREQ*SHIFTWIDTH   shift amount, requester i at [i*SHIFTWIDTH +: SHIFTWIDTH]
//  sh_data_in   out  BUSWIDTH          to shifter data_in
//  sh_rotation  out  1                 to shifter rotation
//  sh_direction out  1                 to shifter direction
//  sh_shift_val out  SHIFTWIDTH        to shifter shift_val
//  sh_data_out  in   BUSWIDTH          from shifter data_out (registered, 1-cycle latency)
//  rsp_valid    out  1                 result valid
//  rsp_ready    in   1                 result accepted by consumer
//  rsp_data     out  BUSWIDTH          result (= sh_data_out while rsp_valid)
//  rsp_id       out  IDW               index of requester that issued the result
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE.
//  - Reset: state=IDLE, cmd regs=0, rr_ptr=NREQ-1, so requester 0 wins first.
//    Reset outputs: req_ready=0, rsp_valid=0, rsp_id=0, sh_*=0.
//  - IDLE: winner = first asserted req_valid searching from rr_ptr+1 modulo NREQ.
//    req_ready[winner]=1 combinationally; all other ready bits 0; ready is 0 in every other state.
//    On the handshake edge: latch data/rot/dir/shamt/id into cmd regs, set rr_ptr=winner, go to ISSUE.
//  - ISSUE (1 cycle): sh_* driven from cmd regs; the shifter registers its result at the end of the cycle.
//    Then go to RESP.
//  - RESP: sh_* remain driven from cmd regs, so sh_data_out stays stable.
//    rsp_valid=1, rsp_data=sh_data_out, rsp_id=cmd id.
//    On rsp_valid & rsp_ready go to IDLE; rsp_valid drops the next cycle.
//  - sh_* outputs always reflect the cmd regs (hold last command in IDLE); no glitching on arbitration.
//  - Latency: accept edge -> rsp_valid high 2 cycles later. Max throughput: 1 result per 3 cycles.
//  - Requester rules: req_* must stay stable while valid and not ready.
//    Deasserting valid without ready is allowed and simply drops out of arbitration.
//  - Fairness: a continuously-requesting client waits at most NREQ-1 transactions.
//  - rsp_ready held low: the FSM stays in RESP indefinitely; no new accepts.
//  - shamt=0: data passes through unchanged (shifter semantics; no special-casing here).
//  - rst asserted mid-operation: in-flight command dropped, rsp_valid=0 asynchronously, rr_ptr reinit.
//  - Shifter reset is the instantiating level's responsibility (invert rst to its rst_n).
// CONFIGURATION
//  SHIFT_SCHED_STATS_EN defined: adds port grant_cnt out NREQ*16.
//    Requester i's counter sits at [i*16 +: 16] and increments on each accept by i.
//    Counters saturate at 16'hFFFF and are cleared by rst.
//  SHIFT_SCHED_STATS_EN undefined: port and counters absent; all other behaviour identical.
// TESTING (bench instantiates the real barrel_shifter, BUSWIDTH=32, NREQ=4)
//  - Single request: req0 data=0x000000F0, rot=0, dir=0, shamt=4, rsp_ready=1.
//    Expect rsp_data=0x00000F00, rsp_id=0, rsp_valid 2 cycles after accept, 1 cycle wide.
//  - Rotate right: req2 data=0x00000001, rot=1, dir=1, shamt=1 -> rsp_data=0x80000000, rsp_id=2.
//  - All 4 valid continuously, from reset -> grant order 0,1,2,3,0; one accept every 3 cycles.
//  - rsp_ready=0 for 10 cycles in RESP: rsp_valid, rsp_data and rsp_id stay stable; all req_ready=0.
//    Then raise rsp_ready -> the next grant goes to the next RR index.
//  - Pulse rst in ISSUE with req1 pending: rsp_valid=0 immediately.
//    After release, req0 (still valid) wins before req1.
//  - With SHIFT_SCHED_STATS_EN: 5 req3 accepts -> grant_cnt[3*16+:16]=5, others 0; rst clears to 0.

Source files
------------

// File: rtl/shift_sched.sv
// shift_sched
//   Round-robin scheduler that shares one registered barrel shifter among
//   NREQ requesters. It accepts one shift command at a time, drives the
//   shifter from a set of command registers, and returns the result on a
//   single valid/ready response port tagged with the issuing requester's ID.
//
//   Ports
//     clk, rst                     clock (posedge), async active-high reset
//     req_valid/req_ready [NREQ]   per-requester handshake (ready one-hot/zero)
//     req_data  [NREQ*BUSWIDTH]    operand, requester i at [i*BUSWIDTH +: BUSWIDTH]
//     req_rot   [NREQ]             1 = rotate, 0 = logical shift
//     req_dir   [NREQ]             0 = left, 1 = right
//     req_shamt [NREQ*SHIFTWIDTH]  shift amount, requester i at [i*SHIFTWIDTH +: SHIFTWIDTH]
//     sh_data_in/sh_rotation/sh_direction/sh_shift_val   to the shifter
//     sh_data_out                  from the shifter (registered, 1 cycle)
//     rsp_valid/rsp_ready          result handshake
//     rsp_data, rsp_id             result and requester index
//
//   Optional feature (macro SHIFT_SCHED_STATS_EN):
//     adds output grant_cnt [NREQ*16]; requester i's saturating accept
//     counter sits at [i*16 +: 16] and is cleared by rst.
//
//   The shifter itself is not reset here; the instantiating level drives its
//   reset (inverted rst).

`ifdef SHIFT_SCHED_STATS_EN
// Per-requester 16-bit saturating accept counter.
module shift_sched_gcnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  output logic [15:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt <= '0;
    else if (inc && cnt != 16'hFFFF)  cnt <= cnt + 16'd1;
  end
endmodule
`endif

module shift_sched #(
  parameter  int NREQ       = 4,
  parameter  int BUSWIDTH   = 32,
  parameter  int SHIFTWIDTH = 5,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*BUSWIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]            req_rot,
  input  logic [NREQ-1:0]            req_dir,
  input  logic [NREQ*SHIFTWIDTH-1:0] req_shamt,
  output logic [BUSWIDTH-1:0]        sh_data_in,
  output logic                       sh_rotation,
  output logic                       sh_direction,
  output logic [SHIFTWIDTH-1:0]      sh_shift_val,
  input  logic [BUSWIDTH-1:0]        sh_data_out,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [BUSWIDTH-1:0]        rsp_data,
  output logic [IDW-1:0]             rsp_id
`ifdef SHIFT_SCHED_STATS_EN
  ,
  output logic [NREQ*16-1:0]         grant_cnt
`endif
);

  if (BUSWIDTH != (1 << SHIFTWIDTH)) begin : g_bad_width
    $error("shift_sched: BUSWIDTH must equal 2**SHIFTWIDTH");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                  state;
  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          win_id;
  logic                    win_vld;
  logic [NREQ-1:0]         acc_vec;

  // Command registers: the shifter is fed only from these, so its inputs
  // never change while arbitration is in progress.
  logic [BUSWIDTH-1:0]     cmd_data;
  logic                    cmd_rot;
  logic                    cmd_dir;
  logic [SHIFTWIDTH-1:0]   cmd_shamt;
  logic [IDW-1:0]          cmd_id;

  // Flat buses have the same bit layout as these packed arrays.
  logic [NREQ-1:0][BUSWIDTH-1:0]   data_a;
  logic [NREQ-1:0][SHIFTWIDTH-1:0] shamt_a;
  assign data_a  = req_data;
  assign shamt_a = req_shamt;

  // Round-robin pick: scan rr_ptr+1 .. rr_ptr+NREQ (mod NREQ). The scan runs
  // from the farthest offset down so the nearest valid requester is the
  // last assignment and wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  // Ready only in IDLE, only to the winner; held low during reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_vld && !rst)
      req_ready[win_id] = 1'b1;
  end

  assign acc_vec = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDW'(NREQ - 1);   // requester 0 wins first
      cmd_data  <= '0;
      cmd_rot   <= 1'b0;
      cmd_dir   <= 1'b0;
      cmd_shamt <= '0;
      cmd_id    <= '0;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|acc_vec) begin
            cmd_data  <= data_a[win_id];
            cmd_rot   <= req_rot[win_id];
            cmd_dir   <= req_dir[win_id];
            cmd_shamt <= shamt_a[win_id];
            cmd_id    <= win_id;
            rr_ptr    <= win_id;
            state     <= ISSUE;
          end
        end
        // Shifter captures its result at the end of this cycle.
        ISSUE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        // Shifter inputs stay on the cmd regs, so sh_data_out holds for as
        // long as the consumer stalls.
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sh_data_in   = cmd_data;
  assign sh_rotation  = cmd_rot;
  assign sh_direction = cmd_dir;
  assign sh_shift_val = cmd_shamt;

  assign rsp_data = sh_data_out;
  assign rsp_id   = cmd_id;

`ifdef SHIFT_SCHED_STATS_EN
  shift_sched_gcnt u_gcnt [NREQ-1:0] (
    .clk (clk),
    .rst (rst),
    .inc (acc_vec),
    .cnt (grant_cnt)
  );
`endif

endmodule
